lpddr2_arbiter: RTL and testbench
=================================

LPDDR2_ARBITER -- requirements
Module: lpddr2_arbiter

Interface
REQ-001 Parameter ADDR_W, default 27, LPDDR2 word-address width.
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for read data.
REQ-003 clk  in  1  single system clock; all logic rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  instruction-fetch read request, level, held until if_done.
REQ-006 if_addr  in  30  instruction-fetch word address.
REQ-007 if_rdata  out  32  fetched word, valid with if_done, held until next if grant.
REQ-008 if_done  out  1  one-cycle completion pulse, fetch port.
REQ-009 d_rreq / d_wreq  in  1 each  data-port read/write request, level, held until d_done.
REQ-010 d_addr  in  30  data word address; d_wdata  in  32  write data.
REQ-011 d_rdata  out  32  read word, valid with d_done, held until next data grant.
REQ-012 d_done  out  1  one-cycle completion pulse, data port.
REQ-013 err  out  1  one-cycle pulse on read timeout.
REQ-014 avm_address  out  ADDR_W  = granted address[ADDR_W-1:0] (upper bits dropped, wrap-around).
REQ-015 avm_read / avm_write  out  1  command strobes; avm_writedata  out  32.
REQ-016 avm_waitrequest  in  1  command not accepted this cycle.
REQ-017 avm_readdata  in  32; avm_readdatavalid  in  1.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT_RD, DONE; exactly one transaction outstanding.
REQ-019 IDLE: on any request, latch port, address, data, direction; go ISSUE next cycle.
REQ-020 Arbitration round-robin: both pending -> grant port not granted last; last_grant resets to fetch (data wins first tie).
REQ-021 d_rreq and d_wreq both high -> write performed, read ignored.
REQ-022 ISSUE: hold avm_read or avm_write plus address/data stable while avm_waitrequest=1.
REQ-023 ISSUE, accepted write (waitrequest=0) -> DONE; accepted read -> WAIT_RD; strobe drops next cycle.
REQ-024 WAIT_RD: on avm_readdatavalid capture avm_readdata into granted port's rdata register -> DONE.
REQ-025 WAIT_RD: cycle counter reaching TIMEOUT without valid -> rdata=32'hDEADBEEF, err pulse, -> DONE.
REQ-026 avm_readdatavalid outside WAIT_RD ignored (stale data after reset/timeout).
REQ-027 DONE: pulse granted port's done for one cycle, toggle last_grant, -> IDLE; minimum 4 cycles per write, 5 per read.
REQ-028 Requests deasserting mid-transaction do not abort it; done still pulses.
REQ-029 Non-granted port outputs unchanged throughout.

Reset
REQ-030 rst forces IDLE, all avm strobes 0, avm_address/writedata 0, done/err 0, if_rdata/d_rdata 0, counter 0, last_grant=fetch.
REQ-031 rst mid-transaction abandons it without done pulse; requesters re-request.

Structure
REQ-032 State enum, port-id enum and DEADBEEF timeout constant in shared package mem_pkg.
REQ-033 Single sub-module rr_arbiter2 (2-way round-robin grant, last_grant register); rest flat.

Verification
REQ-034 d_wreq addr=30'h800, wdata=32'h12345678, waitrequest low -> one avm_write with avm_address=27'h800, d_done 3 cycles later.
REQ-035 if_req and d_rreq same cycle after reset -> data served first, fetch next; readdata 32'hA5A5A5A5 then 32'h5A5A5A5A reach d_rdata, if_rdata.
REQ-036 waitrequest high 6 cycles on read -> avm_read/address stable 7 cycles, single command issued.
REQ-037 No readdatavalid for 255 cycles -> err pulse, d_rdata=32'hDEADBEEF; later stray readdatavalid ignored.
REQ-038 rst asserted in WAIT_RD -> next cycle all outputs 0, no done pulse; subsequent readdatavalid ignored.
REQ-039 d_addr=30'h3FFFFFFF -> avm_address=27'h7FFFFFF; d_rreq+d_wreq together -> write only.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the LPDDR2 two-port arbiter: FSM states, port identities and
// the word returned to a requester whose read timed out.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_DONE
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between the fetch and data ports. The last served
// port is remembered so that a tie always goes to the other one.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_req_if,
  input  logic  i_req_d,
  input  logic  i_update,
  input  port_e i_served,
  output port_e o_grant,
  output logic  o_valid
);

  port_e r_last;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_last <= PORT_IF;
    else if (i_update) r_last <= i_served;
  end

  always_comb begin
    o_valid = i_req_if | i_req_d;
    if (i_req_if && i_req_d) o_grant = (r_last == PORT_IF) ? PORT_D : PORT_IF;
    else if (i_req_d)        o_grant = PORT_D;
    else                     o_grant = PORT_IF;
  end

endmodule

// File: rtl/lpddr2_arbiter.sv
// Serialises instruction-fetch and data-port accesses onto one Avalon-MM master,
// one transaction outstanding, with a read-data timeout.
module lpddr2_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 27,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [29:0]       i_if_addr,
  output logic [31:0]       o_if_rdata,
  output logic              o_if_done,
  input  logic              i_d_rreq,
  input  logic              i_d_wreq,
  input  logic [29:0]       i_d_addr,
  input  logic [31:0]       i_d_wdata,
  output logic [31:0]       o_d_rdata,
  output logic              o_d_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_avm_address,
  output logic              o_avm_read,
  output logic              o_avm_write,
  output logic [31:0]       o_avm_writedata,
  input  logic              i_avm_waitrequest,
  input  logic [31:0]       i_avm_readdata,
  input  logic              i_avm_readdatavalid
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            r_state, w_next;
  port_e             r_port, w_grant;
  logic              r_write, r_tmo;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata, r_if_rdata, r_d_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_if_done, r_d_done, r_err;
  logic              w_req_valid, w_start, w_rd_valid, w_timeout, w_finish;
  logic [31:0]       w_rd_word;
  logic              w_unused;

  assign w_unused = ^{i_if_addr[29:ADDR_W], i_d_addr[29:ADDR_W]};

  rr_arbiter2 u_rr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req_if (i_if_req),
    .i_req_d  (i_d_rreq | i_d_wreq),
    .i_update (w_finish),
    .i_served (r_port),
    .o_grant  (w_grant),
    .o_valid  (w_req_valid)
  );

  // The done pulse cycle is skipped so a requester still holding its level
  // request that cycle is not granted a second time.
  assign w_start    = (r_state == ST_IDLE) && w_req_valid && !r_if_done && !r_d_done;
  assign w_rd_valid = (r_state == ST_WAIT_RD) && i_avm_readdatavalid;
  assign w_timeout  = (r_state == ST_WAIT_RD) && !i_avm_readdatavalid &&
                      (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_rd_word  = w_rd_valid ? i_avm_readdata : TIMEOUT_DATA;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_start) w_next = ST_ISSUE;
      ST_ISSUE:   if (!i_avm_waitrequest) w_next = r_write ? ST_DONE : ST_WAIT_RD;
      ST_WAIT_RD: if (w_rd_valid || w_timeout) w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_avm_read      = (r_state == ST_ISSUE) && !r_write;
    o_avm_write     = (r_state == ST_ISSUE) && r_write;
    o_avm_address   = r_addr;
    o_avm_writedata = r_wdata;
    w_finish        = (r_state == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_port     <= PORT_IF;
      r_write    <= 1'b0;
      r_tmo      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_if_done <= w_finish && (r_port == PORT_IF);
      r_d_done  <= w_finish && (r_port == PORT_D);
      r_err     <= w_finish && r_tmo;
      r_cnt     <= (r_state == ST_WAIT_RD) ? r_cnt + CNT_W'(1) : '0;
      if (w_start) begin
        r_port  <= w_grant;
        r_tmo   <= 1'b0;
        // A simultaneous read and write request on the data port performs the write.
        r_write <= (w_grant == PORT_D) && i_d_wreq;
        r_addr  <= (w_grant == PORT_D) ? i_d_addr[ADDR_W-1:0] : i_if_addr[ADDR_W-1:0];
        if (w_grant == PORT_D) r_wdata <= i_d_wdata;
      end
      if (w_rd_valid || w_timeout) begin
        r_tmo <= w_timeout;
        if (r_port == PORT_IF) r_if_rdata <= w_rd_word;
        else                   r_d_rdata  <= w_rd_word;
      end
    end
  end

  assign o_if_rdata = r_if_rdata;
  assign o_d_rdata  = r_d_rdata;
  assign o_if_done  = r_if_done;
  assign o_d_done   = r_d_done;
  assign o_err      = r_err;

endmodule

// File: tb/tb_lpddr2_arbiter.sv
// Self-checking bench: the bench plays both requesters and the memory slave and
// predicts each transaction from the round-robin and completion rules.
module tb_lpddr2_arbiter;

  localparam int ADDR_W  = 27;
  localparam int TIMEOUT = 255;

  logic              clk;
  logic              rst;
  logic              if_req, d_rreq, d_wreq;
  logic [29:0]       if_addr, d_addr;
  logic [31:0]       d_wdata, if_rdata, d_rdata;
  logic              if_done, d_done, err;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write, waitreq, rvalid;
  logic [31:0]       avm_writedata, rdata_in;

  lpddr2_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_if_req            (if_req),
    .i_if_addr           (if_addr),
    .o_if_rdata          (if_rdata),
    .o_if_done           (if_done),
    .i_d_rreq            (d_rreq),
    .i_d_wreq            (d_wreq),
    .i_d_addr            (d_addr),
    .i_d_wdata           (d_wdata),
    .o_d_rdata           (d_rdata),
    .o_d_done            (d_done),
    .o_err               (err),
    .o_avm_address       (avm_address),
    .o_avm_read          (avm_read),
    .o_avm_write         (avm_write),
    .o_avm_writedata     (avm_writedata),
    .i_avm_waitrequest   (waitreq),
    .i_avm_readdata      (rdata_in),
    .i_avm_readdatavalid (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_done_pulses = 0;
  int n_err_pulses = 0;
  int last_done_cyc = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (if_done) n_done_pulses++;
    if (d_done)  n_done_pulses++;
    if (err)     n_err_pulses++;
  end

  // Reference state: which port was served last, and what each rdata must show.
  bit          m_last_d;
  logic [31:0] m_if_rdata, m_d_rdata;
  logic [31:0] forced_data[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last_d   = 1'b0;
    m_if_rdata = '0;
    m_d_rdata  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"},    avm_read, 1'b0);
    check({tag, "_wr"},    avm_write, 1'b0);
    check({tag, "_addr"},  avm_address, '0);
    check({tag, "_wdata"}, avm_writedata, '0);
    check({tag, "_ifrd"},  if_rdata, '0);
    check({tag, "_drd"},   d_rdata, '0);
    check({tag, "_done"},  {if_done, d_done, err}, 3'b000);
  endtask

  // Serve n back-to-back transactions from the currently held requests.
  task automatic serve(input int n, input int force_waits, input bit tmo);
    int d0, e0, n_tmo;
    d0    = n_done_pulses;
    e0    = n_err_pulses;
    n_tmo = 0;
    for (int t = 0; t < n; t++) begin
      bit to_d, is_wr, both;
      logic [ADDR_W-1:0] ea;
      logic [31:0] rd;
      int waits, bound;
      both  = if_req && (d_rreq || d_wreq);
      to_d  = both ? !m_last_d : (d_rreq || d_wreq);
      is_wr = to_d && d_wreq;
      ea    = to_d ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
      rd    = '0;
      bound = 0;
      while (!(avm_read || avm_write) && bound < 10) begin
        tick();
        bound++;
      end
      check("cmd_seen", avm_read | avm_write, 1'b1);
      if (!(avm_read || avm_write)) return;
      waits = (force_waits >= 0) ? force_waits : $urandom_range(0, 3);
      for (int w = 0; w <= waits; w++) begin
        waitreq = (w < waits);
        check("cmd_write", avm_write, is_wr);
        check("cmd_read", avm_read, !is_wr);
        check("cmd_addr", avm_address, ea);
        if (is_wr) check("cmd_wdata", avm_writedata, d_wdata);
        tick();
      end
      waitreq = 1'b0;
      check("strobe_drop", avm_read | avm_write, 1'b0);
      if (!is_wr) begin
        if (tmo) begin
          repeat (TIMEOUT) tick();
          rd = 32'hDEADBEEF;
          n_tmo++;
        end else begin
          repeat ($urandom_range(0, 3)) tick();
          rd       = (forced_data.size() > 0) ? forced_data.pop_front() : $urandom;
          rvalid   = 1'b1;
          rdata_in = rd;
          tick();
          rvalid   = 1'b0;
          rdata_in = $urandom;
        end
        if (to_d) m_d_rdata = rd;
        else      m_if_rdata = rd;
      end
      tick();
      check("if_done", if_done, !to_d);
      check("d_done", d_done, to_d);
      check("err", err, tmo && !is_wr);
      check("if_rdata", if_rdata, m_if_rdata);
      check("d_rdata", d_rdata, m_d_rdata);
      last_done_cyc = cyc;
      m_last_d = to_d;
      if (to_d) begin
        d_rreq = 1'b0;
        d_wreq = 1'b0;
      end else begin
        if_req = 1'b0;
      end
    end
    tick();
    check("done_count", n_done_pulses - d0, n);
    check("err_count", n_err_pulses - e0, n_tmo);
  endtask

  initial begin
    int req_cyc, d0;
    rst = 1'b1;
    {if_req, d_rreq, d_wreq, waitreq, rvalid} = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0; rdata_in = '0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Simultaneous fetch and data reads after reset: data wins the first tie.
    if_req = 1'b1; if_addr = 30'h0000_0040;
    d_rreq = 1'b1; d_addr  = 30'h0000_0100;
    forced_data.push_back(32'hA5A5A5A5);
    forced_data.push_back(32'h5A5A5A5A);
    serve(2, -1, 1'b0);
    check("tie_d_rdata", d_rdata, 32'hA5A5A5A5);
    check("tie_if_rdata", if_rdata, 32'h5A5A5A5A);

    // Single write, no wait states: done three cycles after the request.
    d_wreq = 1'b1; d_addr = 30'h800; d_wdata = 32'h12345678;
    req_cyc = cyc;
    serve(1, 0, 1'b0);
    check("wr_latency", last_done_cyc - req_cyc, 3);

    // Read held off by six wait-request cycles: command stable seven cycles.
    d_rreq = 1'b1; d_addr = 30'h0123_4567;
    req_cyc = cyc;
    serve(1, 6, 1'b0);

    // Address wrap and read+write collapse to a write.
    d_rreq = 1'b1; d_wreq = 1'b1; d_addr = 30'h3FFF_FFFF; d_wdata = 32'hCAFE_F00D;
    serve(1, -1, 1'b0);

    // Randomised mixes of requests.
    for (int r = 0; r < 40; r++) begin
      bit ion, don;
      ion = $urandom_range(0, 1);
      don = $urandom_range(0, 1);
      if (!ion && !don) don = 1'b1;
      if_addr = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      if_req  = ion;
      if (don) begin
        d_rreq = $urandom_range(0, 1);
        d_wreq = $urandom_range(0, 1);
        if (!d_rreq && !d_wreq) d_rreq = 1'b1;
      end
      serve(int'(ion) + int'(don), -1, 1'b0);
    end

    // Read timeout, then a stray valid while idle must be ignored.
    d_rreq = 1'b1; d_addr = 30'h0000_0777;
    serve(1, 0, 1'b1);
    check("tmo_d_rdata", d_rdata, 32'hDEADBEEF);
    d0 = n_done_pulses;
    rvalid = 1'b1; rdata_in = 32'h1111_2222;
    tick();
    tick();
    rvalid = 1'b0;
    tick();
    check("stray_d_rdata", d_rdata, 32'hDEADBEEF);
    check("stray_if_rdata", if_rdata, m_if_rdata);
    check("stray_done", n_done_pulses - d0, 0);

    // Reset while waiting for read data: abandoned with no done pulse.
    d_rreq = 1'b1; d_addr = 30'h0000_0999;
    begin
      int bound;
      bound = 0;
      while (!avm_read && bound < 10) begin
        tick();
        bound++;
      end
    end
    check("rst_cmd_seen", avm_read, 1'b1);
    waitreq = 1'b0;
    tick();
    d0 = n_done_pulses;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d_rreq = 1'b0;
    model_reset();
    check_all_zero("midrst");
    rvalid = 1'b1; rdata_in = 32'h3333_4444;
    tick();
    rvalid = 1'b0;
    tick();
    tick();
    check("midrst_d_rdata", d_rdata, 32'h0);
    check("midrst_done", n_done_pulses - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
